sdp_be_port_arbiter: RTL
========================

// Module: sdp_be_port_arbiter
// PURPOSE
//  Shares one simple-dual-port byte-enable BRAM (SDP_be: we/be/wa/wd write port, ra/rd read port)
//  between NREQ requesters. Independent round-robin arbiters for the write and read ports.
//  Registered RAM-side outputs. Read data is tagged back to the issuing requester.
//  Read-during-write to the same address is avoided by stalling the read one cycle.
// PARAMETERS
//  NREQ      2   number of requesters (2..4)
//  NBYTES    4   byte lanes per word
//  BYTEWIDTH 8   bits per byte lane
//  WABITS    10  write address width
//  RABITS    10  read address width; must equal WABITS
//  WDBITS    32  write data width; must equal NBYTES*BYTEWIDTH
//  RDBITS    32  read data width; must equal WDBITS
// PORTS
//  clk      in   1              clock, all logic on posedge
//  rst_n    in   1              asynchronous active-low reset
//  wr_req   in   NREQ           per-requester write request, held until granted
//  wr_addr  in   NREQ*WABITS    packed write addresses, requester i at [i*WABITS+:WABITS]
//  wr_data  in   NREQ*WDBITS    packed write data
//  wr_be    in   NREQ*NBYTES    packed byte enables
//  wr_gnt   out  NREQ           one-hot write grant, combinational; transfer = wr_req[i]&wr_gnt[i]
//  rd_req   in   NREQ           per-requester read request, held until granted
//  rd_addr  in   NREQ*RABITS    packed read addresses
//  rd_gnt   out  NREQ           one-hot read grant, combinational
//  rd_vld   out  NREQ           one-hot read-data-valid pulse
//  rd_data  out  RDBITS         read data, shared by all requesters, qualified by rd_vld
//  ram_we   out  1              BRAM write enable (registered)
//  ram_be   out  NBYTES         BRAM byte enables (registered)
//  ram_wa   out  WABITS         BRAM write address (registered)
//  ram_wd   out  WDBITS         BRAM write data (registered)
//  ram_ra   out  RABITS         BRAM read address (registered)
//  ram_rd   in   RDBITS         BRAM read data; valid one clk after ram_ra is presented
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - ram_we=0, ram_be=0, ram_wa/wd/ra=0, rd_vld=0, rd_data=0.
//   - Both RR pointers = 0; read-tag pipeline cleared.
//  Write arbitration (cycle T):
//   - Grant the first wr_req at or after wr_ptr, searching upward and wrapping NREQ-1 -> 0.
//   - On grant: wr_ptr <= winner+1 (mod NREQ). With no requests, wr_ptr holds.
//   - At T+1: ram_we=1 and ram_be/wa/wd = winner's fields.
//   - A write with be==0 is granted but drives ram_we=0. With no grant, ram_we=0.
//  Read arbitration (cycle T):
//   - Same RR scheme with its own rd_ptr; the read candidate is chosen first.
//   - Hazard: if the candidate's rd_addr equals the wr_addr of a write granted in T with be!=0,
//     no read is granted in T and rd_ptr holds. The same requester wins in T+1.
//   - On grant: ram_ra=addr at T+1; ram_rd sampled at end of T+2.
//   - rd_vld[winner] pulses at T+2 with rd_data=ram_rd (combinational pass, qualified by the tag).
//   - Read latency is 2 clk, fully pipelined: one read per cycle sustained.
//  Write/read ordering:
//   - A read granted in T observes every write granted in T-1 or earlier.
//  Simultaneous events:
//   - A write and a read (different addresses, any requesters) are both granted in one cycle.
//   - A requester may hold wr_req and rd_req together; both are arbitrated independently.
//  Reset mid-operation: in-flight reads are dropped with no rd_vld. A write registered into
//   ram_we is cancelled if rst_n falls before the clk edge.
//  Requirements on requesters: req, addr, data and be are stable while req is high and ungranted.
//  Fairness: with all NREQ requesting continuously, each is granted once per NREQ cycles per port.
// TESTING
//  1. Reset: rst_n=0 mid-stream with reads in flight -> all ram_* and rd_vld are 0 immediately.
//     After release, the first grant goes to requester 0.
//  2. Round-robin: NREQ=2, wr_req=2'b11 held 4 cycles -> wr_gnt 01,10,01,10.
//     ram_wa follows requester addresses one cycle later.
//  3. Byte-enable write: req0 writes addr 0x005, wd 0xAABBCCDD, be 4'b0101.
//     Then req1 reads 0x005 -> rd_vld[1] 2 cycles after grant; bytes 0 and 2 = 0xDD and 0xBB.
//  4. Hazard: same cycle, req0 writes 0x010 be=4'hF data 0x12345678 and req1 reads 0x010.
//     -> rd_gnt=0 that cycle, rd_gnt[1] next cycle, rd_data=0x12345678.
//  5. be==0 write: wr_req[0] with be=0 -> wr_gnt[0]=1, ram_we stays 0, RAM contents unchanged.
//  6. Streaming reads: req0 and req1 alternate reads of 8 addresses back-to-back.
//     -> 8 rd_vld pulses in 8 consecutive cycles, each tagged to the correct requester.

Source files
------------

// File: rtl/sdp_be_port_arbiter.sv
// sdp_be_port_arbiter: shares one SDP byte-enable BRAM among NREQ
// requesters with independent round-robin write and read arbiters.
module sdp_be_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int NBYTES    = 4,
  parameter int BYTEWIDTH = 8,
  parameter int WABITS    = 10,
  parameter int RABITS    = 10,
  parameter int WDBITS    = 32,
  parameter int RDBITS    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          wr_req,
  input  logic [NREQ*WABITS-1:0]   wr_addr,
  input  logic [NREQ*WDBITS-1:0]   wr_data,
  input  logic [NREQ*NBYTES-1:0]   wr_be,
  output logic [NREQ-1:0]          wr_gnt,
  input  logic [NREQ-1:0]          rd_req,
  input  logic [NREQ*RABITS-1:0]   rd_addr,
  output logic [NREQ-1:0]          rd_gnt,
  output logic [NREQ-1:0]          rd_vld,
  output logic [RDBITS-1:0]        rd_data,
  output logic                     ram_we,
  output logic [NBYTES-1:0]        ram_be,
  output logic [WABITS-1:0]        ram_wa,
  output logic [WDBITS-1:0]        ram_wd,
  output logic [RABITS-1:0]        ram_ra,
  input  logic [RDBITS-1:0]        ram_rd
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = NBYTES * BYTEWIDTH;

  logic [WABITS-1:0] wa_arr [NREQ];
  logic [LW-1:0]     wd_arr [NREQ];
  logic [NBYTES-1:0] be_arr [NREQ];
  logic [RABITS-1:0] ra_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign wa_arr[g] = wr_addr[g*WABITS +: WABITS];
    assign wd_arr[g] = wr_data[g*WDBITS +: WDBITS];
    assign be_arr[g] = wr_be[g*NBYTES +: NBYTES];
    assign ra_arr[g] = rd_addr[g*RABITS +: RABITS];
  end

  // First set request at or above ptr, wrapping; returns {hit, index}.
  function automatic logic [IW:0] rr_pick(
    input logic [NREQ-1:0] req,
    input logic [IW-1:0]   ptr
  );
    logic [IW:0]   r;
    logic [IW-1:0] ji;
    int            j;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      ji = IW'(j);
      if (req[ji]) r = {1'b1, ji};
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] rr_next(
    input logic [IW-1:0] w
  );
    return (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;
  endfunction

  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_ptr;
  logic [IW:0]   wr_pick;
  logic [IW:0]   rd_pick;
  logic          wr_hit;
  logic          rd_hit;
  logic [IW-1:0] wr_win;
  logic [IW-1:0] rd_win;
  logic          wr_act;
  logic          hazard;
  logic          rd_go;
  logic [NREQ-1:0] rd_tag;

  // Arbitration: write first, then read candidate stalled on
  // a same-address write that will actually hit the RAM.
  always_comb begin
    wr_pick = rr_pick(wr_req, wr_ptr);
    rd_pick = rr_pick(rd_req, rd_ptr);
    wr_hit  = wr_pick[IW];
    wr_win  = wr_pick[IW-1:0];
    rd_hit  = rd_pick[IW];
    rd_win  = rd_pick[IW-1:0];
    wr_act  = wr_hit && (|be_arr[wr_win]);
    hazard  = wr_act &&
              (ra_arr[rd_win] == wa_arr[wr_win]);
    rd_go   = rd_hit && !hazard;
    wr_gnt  = '0;
    rd_gnt  = '0;
    if (wr_hit) wr_gnt[wr_win] = 1'b1;
    if (rd_go)  rd_gnt[rd_win] = 1'b1;
  end

  // Write port: register winner's fields, advance pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      ram_we <= 1'b0;
      ram_be <= '0;
      ram_wa <= '0;
      ram_wd <= '0;
    end else begin
      ram_we <= wr_act;
      if (wr_hit) begin
        wr_ptr <= rr_next(wr_win);
        ram_be <= be_arr[wr_win];
        ram_wa <= wa_arr[wr_win];
        ram_wd <= wd_arr[wr_win];
      end
    end
  end

  // Read port: register address, carry one-hot tag two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      ram_ra <= '0;
      rd_tag <= '0;
      rd_vld <= '0;
    end else begin
      rd_tag <= rd_gnt;
      rd_vld <= rd_tag;
      if (rd_go) begin
        rd_ptr <= rr_next(rd_win);
        ram_ra <= ra_arr[rd_win];
      end
    end
  end

  // RAM data passes through only while a tagged read is valid.
  always_comb begin
    rd_data = (|rd_vld) ? ram_rd : '0;
  end

endmodule
